// File: rtl/lut_arbiter_pkg.sv
// Shared helpers for the lut_arbiter slice: index-width function and the
// packed-key slicing macro used to split the flat request key bus.
package lut_arbiter_pkg;

  // Bit width needed to index n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`ifndef LUT_ARB_KEY_SLICE
// Key of requester r inside a flat vector of w-bit keys.
`define LUT_ARB_KEY_SLICE(vec, r, w) vec[(w)*(r) +: (w)]
`endif

// File: rtl/lut_arbiter_if.sv
// Request/response bus of lut_arbiter.
//   req_valid/req_key : requester side, one bit / one key per requester
//   req_grant         : one-hot, combinational grant back to requesters
//   resp_*            : registered valid/ready response slot
// master = requesters + response consumer, slave = lut_arbiter.
interface lut_arbiter_if
  import lut_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ     = 4,
  parameter int unsigned KEY_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_W       = clog2_min1(NR_REQ)
);

  logic [NR_REQ-1:0]           req_valid;
  logic [NR_REQ*KEY_WIDTH-1:0] req_key;
  logic [NR_REQ-1:0]           req_grant;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [ID_W-1:0]             resp_id;
  logic                        resp_hit;
  logic [DATA_WIDTH-1:0]       resp_data;

  modport master (
    output req_valid, req_key, resp_ready,
    input  req_grant, resp_valid, resp_id, resp_hit, resp_data
  );

  modport slave (
    input  req_valid, req_key, resp_ready,
    output req_grant, resp_valid, resp_id, resp_hit, resp_data
  );

endinterface

// File: rtl/lut_arbiter_rr_arbiter.sv
// Round-robin pick among NR_REQ requests, starting the search at ptr.
//   req   : request vector
//   ptr   : first requester to consider
//   en    : grant allowed this cycle
//   grant : one-hot grant (all zero when nothing granted)
//   id    : encoded index of the granted requester (0 when none)
module lut_arbiter_rr_arbiter
  import lut_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ = 4,
  parameter int unsigned ID_W   = clog2_min1(NR_REQ)
) (
  input  logic [NR_REQ-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  input  logic              en,
  output logic [NR_REQ-1:0] grant,
  output logic [ID_W-1:0]   id
);

  logic            found_c;
  logic [ID_W-1:0] cand_c;

  // Walk ptr, ptr+1, ... with wrap; first asserted request wins.
  always_comb begin
    grant   = '0;
    id      = '0;
    found_c = 1'b0;
    cand_c  = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      cand_c = ID_W'((32'(ptr) + i) % NR_REQ);
      if (en && !found_c && req[cand_c]) begin
        found_c       = 1'b1;
        grant[cand_c] = 1'b1;
        id            = cand_c;
      end
    end
  end

endmodule

// File: rtl/lut_arbiter.sv
// Shared key/data lookup table with round-robin arbitration between
// NR_REQ requesters and a single registered valid/ready response slot.
//   clk, rst       : clock, synchronous active-high reset
//   cfg_we/idx/key/data : write one table entry (idx >= NR_KEY ignored)
//   cfg_clr        : invalidate all entries, wins over cfg_we
//   def            : data returned on a miss, sampled at grant
//   bus            : request/grant and response slot (slave side)
module lut_arbiter
  import lut_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ     = 4,
  parameter int unsigned NR_KEY     = 4,
  parameter int unsigned KEY_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IDX_W      = clog2_min1(NR_KEY),
  parameter int unsigned ID_W       = clog2_min1(NR_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [KEY_WIDTH-1:0]  cfg_key,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_clr,
  input  logic [DATA_WIDTH-1:0] def,
  lut_arbiter_if.slave          bus
);

  logic [NR_KEY-1:0]     ent_valid;
  logic [KEY_WIDTH-1:0]  ent_key  [NR_KEY];
  logic [DATA_WIDTH-1:0] ent_data [NR_KEY];

  logic [KEY_WIDTH-1:0]  req_key_arr [NR_REQ];

  logic [ID_W-1:0]       rr_ptr;
  logic                  slot_free_c;
  logic                  arb_en_c;
  logic [NR_REQ-1:0]     grant_c;
  logic [ID_W-1:0]       gnt_id_c;
  logic                  gnt_any_c;

  logic [KEY_WIDTH-1:0]  lkp_key_c;
  logic                  lkp_hit_c;
  logic [DATA_WIDTH-1:0] lkp_data_c;

  logic                  resp_valid_q;
  logic [ID_W-1:0]       resp_id_q;
  logic                  resp_hit_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  // Unpack the flat key bus into one key per requester.
  for (genvar r = 0; r < NR_REQ; r++) begin : g_key
    assign req_key_arr[r] = `LUT_ARB_KEY_SLICE(bus.req_key, r, KEY_WIDTH);
  end

  // Grants only into a free (or simultaneously drained) slot, never in reset.
  assign slot_free_c = !resp_valid_q || bus.resp_ready;
  assign arb_en_c    = slot_free_c && !rst;

  lut_arbiter_rr_arbiter #(
    .NR_REQ (NR_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .en    (arb_en_c),
    .grant (grant_c),
    .id    (gnt_id_c)
  );

  assign gnt_any_c = |grant_c;
  assign lkp_key_c = req_key_arr[gnt_id_c];

  // Compare against all valid entries; lowest matching index wins.
  always_comb begin
    lkp_hit_c  = 1'b0;
    lkp_data_c = def;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (!lkp_hit_c && ent_valid[i] && (ent_key[i] == lkp_key_c)) begin
        lkp_hit_c  = 1'b1;
        lkp_data_c = ent_data[i];
      end
    end
  end

  // Table update; a lookup in the same cycle still sees the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
    end else if (cfg_clr) begin
      ent_valid <= '0;
    end else if (cfg_we && (32'(cfg_idx) < NR_KEY)) begin
      ent_valid[cfg_idx] <= 1'b1;
      ent_key[cfg_idx]   <= cfg_key;
      ent_data[cfg_idx]  <= cfg_data;
    end
  end

  // Response slot and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      rr_ptr       <= '0;
    end else if (gnt_any_c) begin
      resp_valid_q <= 1'b1;
      resp_id_q    <= gnt_id_c;
      resp_hit_q   <= lkp_hit_c;
      resp_data_q  <= lkp_data_c;
      rr_ptr       <= ID_W'((32'(gnt_id_c) + 32'd1) % NR_REQ);
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.req_grant  = grant_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_lut_arbiter.sv
// Directed bench for lut_arbiter: table programming, hit/miss, round-robin
// order, back-pressure, same-cycle config, clear priority, duplicate keys
// and reset in mid-operation.
module tb_lut_arbiter;
  import lut_arbiter_pkg::*;

  localparam int unsigned NR_REQ     = 4;
  localparam int unsigned NR_KEY     = 4;
  localparam int unsigned KEY_WIDTH  = 4;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned ID_W       = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_we;
  logic [IDX_W-1:0]      cfg_idx;
  logic [KEY_WIDTH-1:0]  cfg_key;
  logic [DATA_WIDTH-1:0] cfg_data;
  logic                  cfg_clr;
  logic [DATA_WIDTH-1:0] def;

  int n_checks = 0;
  int n_fail   = 0;

  lut_arbiter_if #(
    .NR_REQ(NR_REQ), .KEY_WIDTH(KEY_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_W(ID_W)
  ) bus ();

  lut_arbiter #(
    .NR_REQ(NR_REQ), .NR_KEY(NR_KEY), .KEY_WIDTH(KEY_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W), .ID_W(ID_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_key  (cfg_key),
    .cfg_data (cfg_data),
    .cfg_clr  (cfg_clr),
    .def      (def),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic v, input logic [ID_W-1:0] id,
                            input logic hit, input logic [DATA_WIDTH-1:0] data);
    check({tag, ".valid"}, 32'(bus.resp_valid), 32'(v));
    check({tag, ".id"},    32'(bus.resp_id),    32'(id));
    check({tag, ".hit"},   32'(bus.resp_hit),   32'(hit));
    check({tag, ".data"},  32'(bus.resp_data),  32'(data));
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic [KEY_WIDTH-1:0] key,
                           input logic [DATA_WIDTH-1:0] data);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_key  = key;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_order [6] = '{2, 3, 0, 1, 2, 3};

    rst            = 1'b1;
    cfg_we         = 1'b0;
    cfg_idx        = '0;
    cfg_key        = '0;
    cfg_data       = '0;
    cfg_clr        = 1'b0;
    def            = 8'h00;
    bus.req_valid  = 4'hF;
    bus.req_key    = '0;
    bus.resp_ready = 1'b1;

    // Reset: no grant even with requests pending, response cleared.
    tick();
    tick();
    check("rst_grant", 32'(bus.req_grant), 32'h0);
    check_resp("rst", 1'b0, 2'd0, 1'b0, 8'h00);
    rst           = 1'b0;
    bus.req_valid = 4'h0;

    cfg_write(2'd0, 4'd3, 8'hA5);
    cfg_write(2'd1, 4'd7, 8'h3C);

    // Hit: requester 2, key 7.
    bus.req_valid = 4'b0100;
    bus.req_key   = 16'h0700;
    #1;
    check("hit_grant", 32'(bus.req_grant), 32'b0100);
    tick();
    bus.req_valid = 4'h0;
    check_resp("hit", 1'b1, 2'd2, 1'b1, 8'h3C);

    // Miss: requester 1, key 9, def latched at grant (rr_ptr now 3).
    def           = 8'hEE;
    bus.req_valid = 4'b0010;
    bus.req_key   = 16'h0090;
    #1;
    check("miss_grant", 32'(bus.req_grant), 32'b0010);
    tick();
    bus.req_valid  = 4'h0;
    bus.resp_ready = 1'b0;
    def            = 8'h55;
    check_resp("miss", 1'b1, 2'd1, 1'b0, 8'hEE);
    tick();
    check_resp("miss_held", 1'b1, 2'd1, 1'b0, 8'hEE);

    // Round-robin with all requesters valid (rr_ptr now 2).
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'hF;
    bus.req_key    = 16'h3333;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_grant", 32'(bus.req_grant), 32'(1) << exp_order[i]);
      tick();
      check_resp("rr", 1'b1, ID_W'(exp_order[i]), 1'b1, 8'hA5);
    end

    // Back-pressure for 3 cycles: slot held, no grants.
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_grant", 32'(bus.req_grant), 32'h0);
      check_resp("hold", 1'b1, 2'd3, 1'b1, 8'hA5);
      tick();
    end
    // Release: accept and refill in the same cycle (rr_ptr is 0).
    bus.resp_ready = 1'b1;
    #1;
    check("release_grant", 32'(bus.req_grant), 32'b0001);
    tick();
    bus.req_valid = 4'h0;
    check_resp("release", 1'b1, 2'd0, 1'b1, 8'hA5);
    tick();
    check("drain_valid", 32'(bus.resp_valid), 32'h0);

    // Config write in the same cycle as a lookup of the new key (rr_ptr 1).
    cfg_we        = 1'b1;
    cfg_idx       = 2'd0;
    cfg_key       = 4'd5;
    cfg_data      = 8'h11;
    bus.req_valid = 4'b0010;
    bus.req_key   = 16'h0050;
    #1;
    check("samecyc_grant", 32'(bus.req_grant), 32'b0010);
    tick();
    cfg_we = 1'b0;
    check_resp("samecyc", 1'b1, 2'd1, 1'b0, 8'h55);
    #1;
    check("after_grant", 32'(bus.req_grant), 32'b0010);
    tick();
    bus.req_valid = 4'h0;
    check_resp("after", 1'b1, 2'd1, 1'b1, 8'h11);

    // Clear together with a write: clear wins, everything misses.
    cfg_clr  = 1'b1;
    cfg_we   = 1'b1;
    cfg_idx  = 2'd1;
    cfg_key  = 4'd7;
    cfg_data = 8'h77;
    tick();
    cfg_clr = 1'b0;
    cfg_we  = 1'b0;
    bus.req_valid = 4'b0100;
    bus.req_key   = 16'h0700;
    #1;
    check("clr7_grant", 32'(bus.req_grant), 32'b0100);
    tick();
    check_resp("clr7", 1'b1, 2'd2, 1'b0, 8'h55);
    bus.req_valid = 4'b1000;
    bus.req_key   = 16'h5000;
    #1;
    check("clr5_grant", 32'(bus.req_grant), 32'b1000);
    tick();
    bus.req_valid = 4'h0;
    check_resp("clr5", 1'b1, 2'd3, 1'b0, 8'h55);

    // Duplicate keys: lowest index wins (rr_ptr 0).
    cfg_write(2'd2, 4'd4, 8'h22);
    cfg_write(2'd3, 4'd4, 8'h33);
    bus.req_valid = 4'b0001;
    bus.req_key   = 16'h0004;
    #1;
    check("dup_grant", 32'(bus.req_grant), 32'b0001);
    tick();
    check_resp("dup", 1'b1, 2'd0, 1'b1, 8'h22);

    // Reset while a response is held: slot and table discarded.
    bus.resp_ready = 1'b0;
    rst            = 1'b1;
    #1;
    check("midrst_grant", 32'(bus.req_grant), 32'h0);
    tick();
    rst = 1'b0;
    check_resp("midrst", 1'b0, 2'd0, 1'b0, 8'h00);
    bus.resp_ready = 1'b1;
    #1;
    check("postrst_grant", 32'(bus.req_grant), 32'b0001);
    tick();
    bus.req_valid = 4'h0;
    check_resp("postrst", 1'b1, 2'd0, 1'b0, 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_arbiter.md
# lut_arbiter

Shares one key/data lookup table between `NR_REQ` requesters. The block holds up to `NR_KEY` programmable key/data entries and arbitrates lookups round-robin. It returns one registered response per cycle through a valid/ready output slot. It sits between several decode or control units and a single table, replacing per-user table copies.

## Interface
- `NR_REQ`, 4: number of requesters (2..16)
- `NR_KEY`, 4: number of table entries
- `KEY_WIDTH`, 4: key width
- `DATA_WIDTH`, 8: data width
- `IDX_W`, derived `$clog2(NR_KEY)` (min 1): entry index width
- `ID_W`, derived `$clog2(NR_REQ)` (min 1): requester id width

Clock and reset:
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset

Configuration:
- `cfg_we`  in  1  write entry `cfg_idx`
- `cfg_idx`  in  IDX_W  entry index; values ≥ NR_KEY are ignored
- `cfg_key`  in  KEY_WIDTH  key to store
- `cfg_data`  in  DATA_WIDTH  data to store
- `cfg_clr`  in  1  invalidate all entries; takes priority over `cfg_we`
- `def`  in  DATA_WIDTH  data returned on a miss

Requests:
- `req_valid`  in  NR_REQ  one bit per requester
- `req_key`  in  NR_REQ*KEY_WIDTH  packed keys; requester r uses `[KEY_WIDTH*(r+1)-1:KEY_WIDTH*r]`
- `req_grant`  out  NR_REQ  one-hot, combinational; the request is consumed this cycle

Response:
- `resp_valid`  out  1  response slot full
- `resp_ready`  in  1  consumer accepts the response
- `resp_id`  out  ID_W  granted requester
- `resp_hit`  out  1  key matched a valid entry
- `resp_data`  out  DATA_WIDTH  matched data, or `def` latched at the lookup

## Operation
- Table state: NR_KEY entries of {valid, key, data}. All entries are invalid after reset.
- `cfg_clr` clears every valid bit. Otherwise `cfg_we` writes key and data and sets valid at `cfg_idx`.
- A write to an existing entry overwrites it. Duplicate keys are allowed.
- Lookup: compare the key against all valid entries.
  - On multiple matches, the lowest index wins.
  - On no match, `resp_hit` is 0 and `resp_data` is `def`.
- Arbitration: round-robin pointer `rr_ptr`, reset to 0.
  - Search order is `rr_ptr`, `rr_ptr+1`, … with wrap at NR_REQ.
  - The first asserted `req_valid` wins.
- Grant happens only when `slot_free = !resp_valid || resp_ready`.
  - At most one grant per cycle.
  - `req_grant` is all-zero when nothing is granted.
- On a grant to requester g: `rr_ptr` ← (g+1) mod NR_REQ.
  - `rr_ptr` is unchanged on cycles with no grant.
- A requester must hold `req_valid` and its key stable until granted. Dropping `req_valid` before grant is legal and withdraws the request.

## Timing
- Lookup latency: grant in cycle N → response visible (`resp_valid`=1) in cycle N+1.
- Throughput: one response per cycle while `resp_ready`=1.
- Response slot behaviour:
  - It holds `resp_*` stable while `resp_valid && !resp_ready`.
  - While the slot is held, no grants are issued.
  - Accept and refill in the same cycle is allowed.
  - `resp_valid` drops only when accepted with no new grant.
- Config versus lookup in the same cycle: the lookup sees the table contents from before the edge. The write is visible to grants in the next cycle and later.
- `def` is sampled at grant time. A later change does not affect a held response.
- Reset values: `resp_valid`=0, `resp_id`=0, `resp_hit`=0, `resp_data`=0, `rr_ptr`=0, all entries invalid.
  - `req_grant` is 0 during reset.
  - Reset in the middle of operation discards the pending response and the table.

## Structure
- Shared header/package `lut_arbiter_pkg`: width helper for `IDX_W`/`ID_W` and the packed-key slicing macro.
- Sub-module `rr_arbiter` (NR_REQ). Inputs: request vector, pointer, enable. Outputs: one-hot grant and encoded id.
- The table compare and priority encode stay inline in `lut_arbiter`.

## Test plan
- After reset, program entries 0:{3,0xA5} and 1:{7,0x3C}. Requester 2 looks up key 7 → one cycle later `resp_valid`=1, id=2, hit=1, data=0x3C.
- Key 9 with `def`=0xEE → hit=0, data=0xEE. Then change `def` while the response is held → `resp_data` stays 0xEE.
- All 4 requesters valid continuously with `resp_ready`=1 → grants in order 0,1,2,3,0,…, one per cycle.
- Hold `resp_ready`=0 for 3 cycles → `resp_*` stable and `req_grant`=0. On release, the next grant occurs in the same cycle as the accept.
- Write entry 0 = {5,0x11} in the same cycle as a grant for key 5 → response hit=0. A key-5 lookup next cycle → hit=1, data=0x11.
- Assert `cfg_clr` together with `cfg_we` → all entries miss afterwards. Entries 2 and 3 both with key 4 (0x22, 0x33) → data 0x22.
